// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the ID stage: opcodes, FSM encoding, ID/EX bundle.
// The ID/EX bundle widths are fixed to the 32-bit MIPS datapath.
// The bubble value is the all-zero bundle (OutValid=0, every field 0).
package operand_fetch_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [5:0]        op;
    logic [5:0]        funct;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

  // Instructions that actually read rt as a source (as opposed to writing it).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Operand resolve mux: priority EX > MEM > WB > RegFile, register 0 forced to 0.
// Purely combinational, zero latency.
// A load in EX is never forwarded; the hazard logic stalls for that case instead.
module operand_bypass
  import operand_fetch_stage_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic [AW-1:0] rn_i,
  input  logic [DW-1:0] rf_dat_i,
  input  logic [AW-1:0] ex_wn_i,
  input  logic          ex_write_i,
  input  logic          ex_is_load_i,
  input  logic [DW-1:0] ex_result_i,
  input  logic [AW-1:0] mem_wn_i,
  input  logic          mem_write_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic [AW-1:0] wb_wn_i,
  input  logic          wb_write_i,
  input  logic [DW-1:0] wb_wd_i,
  output logic [DW-1:0] opnd_o
);

  // Youngest producer wins; a load in EX falls through to older stages.
  always_comb begin
    opnd_o = rf_dat_i;
    if (rn_i == '0) begin
      opnd_o = '0;
    end else if (ex_write_i && !ex_is_load_i && (ex_wn_i == rn_i)) begin
      opnd_o = ex_result_i;
    end else if (mem_write_i && (mem_wn_i == rn_i)) begin
      opnd_o = mem_result_i;
    end else if (wb_write_i && (wb_wn_i == rn_i)) begin
      opnd_o = wb_wd_i;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID stage: RegFile addressing, operand bypass, load-use stall, ID/EX register.
// Latency one cycle IF/ID -> ID/EX; two cycles when a load-use bubble is inserted.
// Stall holds PC and IF/ID for exactly one cycle per load; Flush kills ID/EX and wins.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  // The ID/EX bundle is sized by the package; keep these at their defaults.
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  input  logic [31:0]   in_instr_i,
  input  logic [DW-1:0] in_pc_i,
  input  logic          flush_i,
  output logic [AW-1:0] rn1_o,
  output logic [AW-1:0] rn2_o,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [AW-1:0] ex_wn_i,
  input  logic          ex_write_i,
  input  logic          ex_is_load_i,
  input  logic [DW-1:0] ex_result_i,
  input  logic [AW-1:0] mem_wn_i,
  input  logic          mem_write_i,
  input  logic [DW-1:0] mem_result_i,
  input  logic [AW-1:0] wb_wn_i,
  input  logic          wb_write_i,
  input  logic [DW-1:0] wb_wd_i,
  output logic          stall_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_pc_o,
  output logic [DW-1:0] out_a_o,
  output logic [DW-1:0] out_b_o,
  output logic [DW-1:0] out_imm_o,
  output logic [AW-1:0] out_rt_o,
  output logic [AW-1:0] out_rd_o,
  output logic [5:0]    out_op_o,
  output logic [5:0]    out_funct_o
);

  state_e        state_q;
  idex_t         idex_q;
  idex_t         idex_d;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;
  logic [5:0]    op;
  logic          hazard;

  assign op    = in_instr_i[31:26];
  assign rn1_o = in_instr_i[25:21];
  assign rn2_o = in_instr_i[20:16];

  operand_bypass #(.DW(DW), .AW(AW)) u_byp_a (
    .rn_i(rn1_o), .rf_dat_i(a_i),
    .ex_wn_i(ex_wn_i), .ex_write_i(ex_write_i), .ex_is_load_i(ex_is_load_i), .ex_result_i(ex_result_i),
    .mem_wn_i(mem_wn_i), .mem_write_i(mem_write_i), .mem_result_i(mem_result_i),
    .wb_wn_i(wb_wn_i), .wb_write_i(wb_write_i), .wb_wd_i(wb_wd_i),
    .opnd_o(opnd_a)
  );

  operand_bypass #(.DW(DW), .AW(AW)) u_byp_b (
    .rn_i(rn2_o), .rf_dat_i(b_i),
    .ex_wn_i(ex_wn_i), .ex_write_i(ex_write_i), .ex_is_load_i(ex_is_load_i), .ex_result_i(ex_result_i),
    .mem_wn_i(mem_wn_i), .mem_write_i(mem_write_i), .mem_result_i(mem_result_i),
    .wb_wn_i(wb_wn_i), .wb_write_i(wb_write_i), .wb_wd_i(wb_wd_i),
    .opnd_o(opnd_b)
  );

  // rt only counts as a source for instructions that read it; I-type ALU ops write it.
  assign hazard = in_valid_i && ex_is_load_i && ex_write_i && (ex_wn_i != '0) &&
                  ((ex_wn_i == rn1_o) || ((ex_wn_i == rn2_o) && uses_rt(op)));

  // Reset and Flush both suppress the stall in the same cycle they are seen.
  assign stall_o = !rst_i && !flush_i && (state_q == ST_RUN) && hazard;

  // Decode the IF/ID slot into the next ID/EX bundle.
  always_comb begin
    idex_d       = IDEX_BUBBLE;
    idex_d.valid = in_valid_i;
    idex_d.pc    = in_pc_i;
    idex_d.a     = opnd_a;
    idex_d.b     = opnd_b;
    idex_d.imm   = {{16{in_instr_i[15]}}, in_instr_i[15:0]};
    idex_d.rt    = in_instr_i[20:16];
    idex_d.rd    = in_instr_i[15:11];
    idex_d.op    = op;
    idex_d.funct = in_instr_i[5:0];
  end

  // Hazard FSM and ID/EX register; BUBBLE ignores the hazard so each load costs one bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      idex_q  <= IDEX_BUBBLE;
    end else if (flush_i) begin
      state_q <= ST_RUN;
      idex_q  <= IDEX_BUBBLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            state_q <= ST_BUBBLE;
            idex_q  <= IDEX_BUBBLE;
          end else begin
            idex_q  <= idex_d;
          end
        end
        ST_BUBBLE: begin
          state_q <= ST_RUN;
          idex_q  <= idex_d;
        end
      endcase
    end
  end

  assign out_valid_o = idex_q.valid;
  assign out_pc_o    = idex_q.pc;
  assign out_a_o     = idex_q.a;
  assign out_b_o     = idex_q.b;
  assign out_imm_o   = idex_q.imm;
  assign out_rt_o    = idex_q.rt;
  assign out_rd_o    = idex_q.rd;
  assign out_op_o    = idex_q.op;
  assign out_funct_o = idex_q.funct;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed vectors, a behavioural model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush;
  logic [31:0] instr, pc, a, b;
  logic [4:0]  ex_wn, mem_wn, wb_wn;
  logic        ex_write, ex_is_load, mem_write, wb_write;
  logic [31:0] ex_result, mem_result, wb_wd;
  logic [4:0]  rn1, rn2, out_rt, out_rd;
  logic        stall, out_valid;
  logic [31:0] out_pc, out_a, out_b, out_imm;
  logic [5:0]  out_op, out_funct;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rt, rd;
    logic [5:0]  op, funct;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  logic mdl_bubble_spent = 1'b0;
  logic stall_seen;

  always #5 clk = ~clk;

  operand_fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_instr_i(instr), .in_pc_i(pc),
    .flush_i(flush), .rn1_o(rn1), .rn2_o(rn2), .a_i(a), .b_i(b),
    .ex_wn_i(ex_wn), .ex_write_i(ex_write), .ex_is_load_i(ex_is_load), .ex_result_i(ex_result),
    .mem_wn_i(mem_wn), .mem_write_i(mem_write), .mem_result_i(mem_result),
    .wb_wn_i(wb_wn), .wb_write_i(wb_write), .wb_wd_i(wb_wd),
    .stall_o(stall), .out_valid_o(out_valid), .out_pc_o(out_pc), .out_a_o(out_a), .out_b_o(out_b),
    .out_imm_o(out_imm), .out_rt_o(out_rt), .out_rd_o(out_rd), .out_op_o(out_op), .out_funct_o(out_funct)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Model of a register read: youngest non-load writer of that register, else RegFile.
  function automatic logic [31:0] resolve(input logic [4:0] rn, input logic [31:0] rf);
    if (rn == 5'd0) return 32'd0;
    if (ex_write && !ex_is_load && ex_wn == rn) return ex_result;
    if (mem_write && mem_wn == rn) return mem_result;
    if (wb_write && wb_wn == rn) return wb_wd;
    return rf;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // One clock: check the combinational outputs mid-cycle, predict ID/EX, check after the edge.
  task automatic step();
    logic [5:0] op;
    logic       reads_rt, hz, st;
    exp_t       nx, act;
    @(negedge clk);
    op       = instr[31:26];
    reads_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2b);
    hz = in_valid && ex_is_load && ex_write && (ex_wn != 5'd0) &&
         ((ex_wn == instr[25:21]) || (reads_rt && ex_wn == instr[20:16]));
    st = !rst && !flush && !mdl_bubble_spent && hz;
    chk("rn1", {27'd0, rn1}, {27'd0, instr[25:21]});
    chk("rn2", {27'd0, rn2}, {27'd0, instr[20:16]});
    chk("stall", {31'd0, stall}, {31'd0, st});
    stall_seen = stall;
    if (rst || flush || st) nx = '0;
    else nx = '{v: in_valid, pc: pc, a: resolve(instr[25:21], a), b: resolve(instr[20:16], b),
                imm: {{16{instr[15]}}, instr[15:0]}, rt: instr[20:16], rd: instr[15:11],
                op: instr[31:26], funct: instr[5:0]};
    mdl_bubble_spent = st;
    @(posedge clk);
    #1;
    act = '{v: out_valid, pc: out_pc, a: out_a, b: out_b, imm: out_imm, rt: out_rt,
            rd: out_rd, op: out_op, funct: out_funct};
    checks++;
    if (act !== nx) begin
      errors++;
      $display("FAIL idex: got %h, want %h", act, nx);
    end
  endtask

  task automatic quiet_pipe();
    ex_write = 0; ex_is_load = 0; ex_wn = 0; ex_result = 0;
    mem_write = 0; mem_wn = 0; mem_result = 0;
    wb_write = 0; wb_wn = 0; wb_wd = 0;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 1; pc = 32'h4; a = 32'd11; b = 32'd22;
    instr = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    quiet_pipe();
    ex_wn = 1; ex_write = 1; ex_result = 32'd5;
    mem_wn = 1; mem_write = 1; mem_result = 32'd7;

    // 1. Reset held two cycles with a valid instruction present.
    step(); step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_stall", {31'd0, stall_seen}, 32'd0);

    // 2. First edge after reset loads add $3,$1,$2; EX beats MEM.
    rst = 0;
    step();
    chk("ex_wins", out_a, 32'd5);
    chk("rf_b", out_b, 32'd22);
    chk("load_rd", {27'd0, out_rd}, 32'd3);
    chk("load_pc", out_pc, 32'h4);
    ex_write = 0; pc = 32'h8;
    step();
    chk("mem_after_ex", out_a, 32'd7);

    // 3. WB bypass over stale RegFile; register 0 ignores any writer.
    quiet_pipe();
    b = 32'd0; wb_wn = 2; wb_write = 1; wb_wd = 32'h1234;
    step();
    chk("wb_b", out_b, 32'h1234);
    instr = rtype(5'd0, 5'd2, 5'd3, 6'h20); a = 32'h55;
    ex_wn = 0; ex_write = 1; ex_result = 32'd9;
    step();
    chk("zero_reg", out_a, 32'd0);

    // 4. Load-use: lw $4 in EX, add $5,$4,$4 in ID -> one bubble, then MEM bypass.
    quiet_pipe();
    a = 32'h1; b = 32'h2; pc = 32'h10;
    instr = rtype(5'd4, 5'd4, 5'd5, 6'h20);
    ex_wn = 4; ex_write = 1; ex_is_load = 1; ex_result = 32'hdead;
    step();
    chk("lu_stall", {31'd0, stall_seen}, 32'd1);
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    quiet_pipe();
    mem_wn = 4; mem_write = 1; mem_result = 32'h77;
    step();
    chk("lu_release", {31'd0, stall_seen}, 32'd0);
    chk("lu_a", out_a, 32'h77);
    chk("lu_b", out_b, 32'h77);
    chk("lu_rd", {27'd0, out_rd}, 32'd5);

    // sw reads rt, so a load to rt stalls; the EX load is still present in BUBBLE and is ignored.
    quiet_pipe();
    instr = itype(OP_SW, 5'd1, 5'd4, 16'h0008);
    ex_wn = 4; ex_write = 1; ex_is_load = 1;
    step();
    chk("sw_stall", {31'd0, stall_seen}, 32'd1);
    step();
    chk("bubble_once", {31'd0, stall_seen}, 32'd0);
    chk("sw_b_rf", out_b, 32'h2);

    // 5. addi $4,$1,3 only writes rt: no hazard; negative immediate sign-extends.
    instr = itype(6'h08, 5'd1, 5'd4, 16'h0003);
    step();
    chk("addi_nostall", {31'd0, stall_seen}, 32'd0);
    chk("addi_imm", out_imm, 32'h3);
    chk("addi_op", {26'd0, out_op}, 32'h8);
    instr = itype(OP_LW, 5'd2, 5'd6, 16'hfffe);
    ex_wn = 7;
    step();
    chk("sext", out_imm, 32'hfffffffe);

    // 6. Hazard with Flush: no stall, bubble, stay RUN (next hazard stalls).
    instr = rtype(5'd4, 5'd4, 5'd5, 6'h20);
    ex_wn = 4; flush = 1;
    step();
    chk("flush_stall", {31'd0, stall_seen}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    flush = 0;
    step();
    chk("run_after_flush", {31'd0, stall_seen}, 32'd1);
    // Now in BUBBLE: reset drops Stall immediately and returns to RUN.
    rst = 1;
    step();
    chk("rst_bub_stall", {31'd0, stall_seen}, 32'd0);
    chk("rst_bub_valid", {31'd0, out_valid}, 32'd0);
    rst = 0;
    step();
    chk("run_after_rst", {31'd0, stall_seen}, 32'd1);
    // Flush during BUBBLE also wins.
    flush = 1;
    step();
    chk("flush_bub_valid", {31'd0, out_valid}, 32'd0);
    flush = 0; quiet_pipe();
    step();
    chk("final_valid", {31'd0, out_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
